// File: rtl/cpu_pkg.sv
// Shared types and field positions for the LEGv8 fetch / next-PC engine.
package cpu_pkg;

  localparam int ADDR_W_DEF = 64;

  // Two-phase instruction sequencing: fetch the word, then execute and retire it.
  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } seq_state_t;

  // Condition flags in {N,Z,V,C} order.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Instruction word field positions.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 21;
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch bus plus decoder/ALU side-band between the sequencer (master) and
// instruction memory / control unit / datapath (slave).
interface pc_sequencer_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [31:0]       instr_in;
  logic [31:0]       instr;
  logic [10:0]       opcode;
  logic              uncond_branch;
  logic              br_taken;
  logic              check_for_lt;
  logic              branch_register;
  logic              branch_link;
  logic              set_flag;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_carry;
  logic [ADDR_W-1:0] reg_data;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_addr;
  logic [3:0]        flags;
  logic              commit;

  modport master (
    output fetch_req, fetch_addr, instr, opcode, pc, link_addr, flags, commit,
    input  fetch_ack, instr_in, uncond_branch, br_taken, check_for_lt,
           branch_register, branch_link, set_flag, alu_negative, alu_zero,
           alu_overflow, alu_carry, reg_data, stall
  );

  modport slave (
    input  fetch_req, fetch_addr, instr, opcode, pc, link_addr, flags, commit,
    output fetch_ack, instr_in, uncond_branch, br_taken, check_for_lt,
           branch_register, branch_link, set_flag, alu_negative, alu_zero,
           alu_overflow, alu_carry, reg_data, stall
  );
endinterface

// File: rtl/branch_target.sv
// Branch decision and next-PC arithmetic for the instruction in EXEC.
// Purely combinational; all sums wrap at ADDR_W bits.
module branch_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       imm,
  input  logic              flag_n,
  input  logic              flag_v,
  input  logic [ADDR_W-1:0] reg_data,
  input  logic              uncond_branch,
  input  logic              br_taken,
  input  logic              check_for_lt,
  input  logic              branch_register,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] off26;
  logic [ADDR_W-1:0] off19;
  logic [ADDR_W-1:0] target;
  logic              cond;
  logic              taken;

  // Sign-extend/shift offsets, pick target, gate on br_taken so stray
  // controls on non-branch instructions always fall through to pc+4.
  always_comb begin
    off26    = {{(ADDR_W-28){imm[IMM26_MSB]}}, imm[IMM26_MSB:IMM26_LSB], 2'b00};
    off19    = {{(ADDR_W-21){imm[IMM19_MSB]}}, imm[IMM19_MSB:IMM19_LSB], 2'b00};
    cond     = check_for_lt ? (flag_n != flag_v) : alu_zero;
    taken    = br_taken & (uncond_branch | cond);
    pc_plus4 = pc + ADDR_W'(4);
    if (branch_register)    target = reg_data;
    else if (uncond_branch) target = pc + off26;
    else                    target = pc + off19;
    next_pc  = taken ? target : pc_plus4;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch and next-PC engine: fetches a word over req/ack, holds it
// while the datapath executes (optionally stalled), then retires it by
// committing the next PC and, when requested, the NZVC flags.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset_n,
  pc_sequencer_if.master bus
);

  seq_state_t        state;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  flags_t            flags_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;
  logic              retire;

  branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
    .pc              (pc_q),
    .imm             (instr_q[IMM26_MSB:IMM26_LSB]),
    .flag_n          (flags_q.n),
    .flag_v          (flags_q.v),
    .reg_data        (bus.reg_data),
    .uncond_branch   (bus.uncond_branch),
    .br_taken        (bus.br_taken),
    .check_for_lt    (bus.check_for_lt),
    .branch_register (bus.branch_register),
    .alu_zero        (bus.alu_zero),
    .pc_plus4        (pc_plus4),
    .next_pc         (next_pc)
  );

  // An instruction retires on the last (unstalled) EXEC cycle.
  assign retire = (state == EXEC) && !bus.stall;

  // Sequencer FSM: latch the fetched word, then commit pc/flags on retire.
  // Reset aborts whatever is in flight, so nothing is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.fetch_ack) begin
            instr_q <= bus.instr_in;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (!bus.stall) begin
            pc_q  <= next_pc;
            state <= FETCH;
            if (bus.set_flag) begin
              flags_q <= '{n: bus.alu_negative, z: bus.alu_zero,
                           v: bus.alu_overflow, c: bus.alu_carry};
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Request is qualified by reset_n so it drops the moment reset asserts.
  assign bus.fetch_req  = (state == FETCH) && reset_n;
  assign bus.fetch_addr = pc_q;
  assign bus.instr      = instr_q;
  assign bus.opcode     = instr_q[OPC_MSB:OPC_LSB];
  assign bus.pc         = pc_q;
  assign bus.link_addr  = pc_plus4;
  assign bus.flags      = flags_q;
  assign bus.commit     = retire;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a driver walks instructions through FETCH/EXEC,
// a reference model predicts each retirement, and a monitor checks commits.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(64)) bus();

  pc_sequencer #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] nxt;
    logic [3:0]  fl;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_pc = 64'h0;
  logic [3:0]  m_flags = 4'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: after each retirement, pc and flags must equal the prediction.
  logic pend = 1'b0;
  exp_t cur_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("post_pc", bus.pc, cur_e.nxt);
        chk("post_flags", {60'h0, bus.flags}, {60'h0, cur_e.fl});
        pend = 1'b0;
      end
      if (bus.commit) begin
        if (sbq.size() == 0) begin
          chk("unexpected_commit", 64'h1, 64'h0);
        end else begin
          cur_e = sbq.pop_front();
          chk("commit_pc", bus.pc, cur_e.pc);
          chk("commit_link", bus.link_addr, cur_e.pc + 64'd4);
          pend = 1'b1;
        end
      end
    end
  end

  // One instruction through the sequencer; the model is the ISA rule set.
  task automatic run_instr(input logic [31:0] word, input int waits, input int stalls,
                           input bit ub, input bit bt, input bit lt, input bit brr,
                           input bit bl, input bit sf, input bit an, input bit az,
                           input bit av, input bit ac, input logic [63:0] rd);
    logic [63:0] cur;
    logic [63:0] tgt;
    bit          cond;
    bit          tk;
    exp_t        e;
    cur = m_pc;
    chk("fetch_req", {63'h0, bus.fetch_req}, 64'h1);
    chk("fetch_addr", bus.fetch_addr, cur);
    for (int w = 0; w < waits; w++) begin
      bus.fetch_ack = 1'b0;
      bus.instr_in  = $urandom;
      step();
      chk("fetch_req_held", {63'h0, bus.fetch_req}, 64'h1);
      chk("fetch_addr_stable", bus.fetch_addr, cur);
    end
    cond = lt ? (m_flags[3] != m_flags[1]) : az;
    tk   = bt && (ub || cond);
    if (brr)     tgt = rd;
    else if (ub) tgt = cur + longint'($signed(word[25:0])) * 4;
    else         tgt = cur + longint'($signed(word[23:5])) * 4;
    e.pc  = cur;
    e.nxt = tk ? tgt : cur + 64'd4;
    e.fl  = sf ? {an, az, av, ac} : m_flags;
    sbq.push_back(e);
    m_pc    = e.nxt;
    m_flags = e.fl;
    bus.uncond_branch   = ub;
    bus.br_taken        = bt;
    bus.check_for_lt    = lt;
    bus.branch_register = brr;
    bus.branch_link     = bl;
    bus.set_flag        = sf;
    bus.alu_negative    = an;
    bus.alu_zero        = az;
    bus.alu_overflow    = av;
    bus.alu_carry       = ac;
    bus.reg_data        = rd;
    bus.stall           = (stalls > 0);
    bus.fetch_ack       = 1'b1;
    bus.instr_in        = word;
    step();
    bus.fetch_ack = 1'($urandom_range(0, 1));
    bus.instr_in  = $urandom;
    chk("instr", {32'h0, bus.instr}, {32'h0, word});
    chk("opcode", {53'h0, bus.opcode}, {53'h0, word[31:21]});
    chk("link_exec", bus.link_addr, cur + 64'd4);
    for (int s = 0; s < stalls; s++) begin
      chk("commit_in_stall", {63'h0, bus.commit}, 64'h0);
      step();
      chk("pc_in_stall", bus.pc, cur);
    end
    bus.stall = 1'b0;
    #1;
    chk("commit_pulse", {63'h0, bus.commit}, 64'h1);
    step();
    bus.fetch_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.fetch_ack = 0; bus.instr_in = 0; bus.uncond_branch = 0; bus.br_taken = 0;
    bus.check_for_lt = 0; bus.branch_register = 0; bus.branch_link = 0;
    bus.set_flag = 0; bus.alu_negative = 0; bus.alu_zero = 0; bus.alu_overflow = 0;
    bus.alu_carry = 0; bus.reg_data = 0; bus.stall = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fetch_req", {63'h0, bus.fetch_req}, 64'h0);
    chk("rst_pc", bus.pc, 64'h0);
    chk("rst_instr", {32'h0, bus.instr}, 64'h0);
    chk("rst_flags", {60'h0, bus.flags}, 64'h0);
    chk("rst_commit", {63'h0, bus.commit}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // ADDI after a 3-cycle memory wait, no branch
    run_instr(32'h91000421, 3, 0, 0,0,0,0,0, 0, 0,0,0,0, 64'h0);
    chk("addi_pc", bus.pc, 64'h4);
    // BR to 0x100, then B -2 words
    run_instr(32'hD61F0000, 0, 0, 1,1,0,1,0, 0, 0,0,0,0, 64'h100);
    run_instr(32'h17FFFFFE, 1, 0, 1,1,0,0,0, 0, 0,0,0,0, 64'h0);
    chk("b_back_pc", bus.pc, 64'hF8);
    // SUBS N=1 V=0 at 0x1C, then B.LT +4 at 0x20
    run_instr(32'hD61F0000, 0, 0, 1,1,0,1,0, 0, 0,0,0,0, 64'h1C);
    run_instr(32'hEB020020, 0, 0, 0,0,0,0,0, 1, 1,0,0,0, 64'h0);
    chk("subs_flags", {60'h0, bus.flags}, 64'h8);
    run_instr(32'h5400008B, 0, 0, 0,1,1,0,0, 0, 0,0,0,0, 64'h0);
    chk("blt_taken_pc", bus.pc, 64'h30);
    // SUBS N=V, B.LT falls through; it also sets flags in the same instr
    run_instr(32'hD61F0000, 0, 0, 1,1,0,1,0, 0, 0,0,0,0, 64'h1C);
    run_instr(32'hEB020020, 2, 0, 0,0,0,0,0, 1, 1,0,1,0, 64'h0);
    run_instr(32'h5400008B, 0, 0, 0,1,1,0,0, 1, 1,0,0,1, 64'h0);
    chk("blt_fall_pc", bus.pc, 64'h24);
    chk("blt_newflags", {60'h0, bus.flags}, 64'h9);
    // CBZ -1 at 0x40, zero and non-zero
    run_instr(32'hD61F0000, 0, 0, 1,1,0,1,0, 0, 0,0,0,0, 64'h40);
    run_instr(32'hB4FFFFE0, 0, 0, 0,1,0,0,0, 0, 0,1,0,0, 64'h0);
    chk("cbz_taken_pc", bus.pc, 64'h3C);
    run_instr(32'hD61F0000, 0, 0, 1,1,0,1,0, 0, 0,0,0,0, 64'h40);
    run_instr(32'hB4FFFFE0, 0, 0, 0,1,0,0,0, 0, 0,0,0,0, 64'h0);
    chk("cbz_fall_pc", bus.pc, 64'h44);
    // BR with a 2-cycle stall
    run_instr(32'hD61F03C0, 0, 2, 1,1,0,1,0, 0, 0,0,0,0, 64'hDEADBEE0);
    chk("br_pc", bus.pc, 64'hDEADBEE0);
    // br_taken=0 with every other control set falls through
    run_instr(32'h17FFFFFE, 0, 1, 1,0,1,1,1, 0, 0,1,0,0, 64'h1234);
    chk("no_br_pc", bus.pc, 64'hDEADBEE4);

    // Randomised instruction stream
    for (int i = 0; i < 200; i++) begin
      run_instr($urandom, int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
                ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                {$urandom, $urandom});
    end

    // Reset while in EXEC with a pending flag write
    bus.set_flag = 1; bus.alu_negative = 1; bus.alu_zero = 1; bus.alu_overflow = 1;
    bus.alu_carry = 1; bus.stall = 0; bus.br_taken = 0;
    bus.fetch_ack = 1; bus.instr_in = 32'h91000421;
    step();
    bus.fetch_ack = 0;
    reset_n = 1'b0;
    #1;
    chk("abort_fetch_req", {63'h0, bus.fetch_req}, 64'h0);
    chk("abort_pc", bus.pc, 64'h0);
    chk("abort_flags", {60'h0, bus.flags}, 64'h0);
    chk("abort_commit", {63'h0, bus.commit}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_pc = 64'h0;
    m_flags = 4'h0;
    step();
    run_instr(32'h91000421, 1, 0, 0,0,0,0,0, 0, 0,0,0,0, 64'h0);
    chk("after_abort_pc", bus.pc, 64'h4);
    chk("after_abort_flags", {60'h0, bus.flags}, 64'h0);

    repeat (3) step();
    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
